// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam logic PAR_EVEN   = 1'b0;
   localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for the latched transmit word.
module uart_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_typ_i,
   output logic                  par_bit_o
);

   always_comb begin
      case (par_typ_i)
         PAR_EVEN: par_bit_o = ^data_i;
         PAR_ODD:  par_bit_o = ~(^data_i);
         default:  par_bit_o = ^data_i;
      endcase
   end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit; one bit per CLK.
module uart_tx_top
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   tx_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    par_en_q, par_en_d;
   logic                    par_typ_q, par_typ_d;
   logic                    tx_q, tx_d;
   logic                    busy_q, busy_d;
   logic                    par_bit;

   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data_i    (data_q),
      .par_typ_i (par_typ_q),
      .par_bit_o (par_bit)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      case (state_q)
         IDLE: begin
            if (Data_Valid) begin
               state_d   = START;
               data_d    = P_DATA;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
            end
         end
         START:  state_d = DATA;
         DATA: begin
            if (cnt_q == LAST_BIT) begin
               state_d = par_en_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: state_d = STOP;
         STOP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      tx_d   = IDLE_LEVEL;
      busy_d = (state_d != IDLE);
      case (state_d)
         IDLE:    tx_d = IDLE_LEVEL;
         START:   tx_d = START_BIT;
         DATA:    tx_d = data_q[cnt_d];
         PARITY:  tx_d = par_bit;
         STOP:    tx_d = STOP_BIT;
         default: tx_d = IDLE_LEVEL;
      endcase
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: queue-based frame model checked every cycle plus literal frame vectors.
module tb_uart_tx_top;

   logic       CLK        = 1'b0;
   logic       RST        = 1'b1;
   logic [7:0] P_DATA     = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN     = 1'b0;
   logic       PAR_TYP    = 1'b0;
   logic       TX_OUT;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   bit q[$];
   bit mvalid = 1'b0;

   uart_tx_top #(
      .DATA_WIDTH (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each accepted word becomes a queue of line bits; the head is what the line shows.
   always @(posedge CLK) begin
      if (RST) begin
         q.delete();
         mvalid = 1'b1;
      end else if (q.size() != 0) begin
         void'(q.pop_front());
      end else if (Data_Valid) begin
         q.push_back(1'b0);
         for (int i = 0; i < 8; i++) q.push_back(P_DATA[i]);
         if (PAR_EN) q.push_back((($countones(P_DATA) + int'(PAR_TYP)) % 2) == 1);
         q.push_back(1'b1);
      end
      #1;
      if (mvalid) begin
         chk("model_tx", {31'd0, TX_OUT}, {31'd0, (q.size() != 0) ? q[0] : 1'b1});
         chk("model_busy", {31'd0, busy}, {31'd0, q.size() != 0});
      end
   end

   task automatic send_frame(input string name, input logic [7:0] d, input logic pen,
                             input logic ptyp, input int unsigned len,
                             input logic [10:0] exp, input bit disturb);
      logic [10:0] vec  = '0;
      int unsigned bcnt = 0;
      @(negedge CLK);
      P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
      for (int unsigned i = 0; i < len; i++) begin
         @(posedge CLK); #1;
         if (i == 0) Data_Valid = 1'b0;
         if (disturb) begin
            case (i)
               3: begin P_DATA = 8'h00; PAR_EN = ~pen; PAR_TYP = ~ptyp; Data_Valid = 1'b1; end
               5: Data_Valid = 1'b0;
               7: Data_Valid = 1'b1;
               9: Data_Valid = 1'b0;
               default: ;
            endcase
         end
         vec[i] = TX_OUT;
         if (busy) bcnt++;
      end
      @(posedge CLK); #1;
      chk({name, "_bits"}, {21'd0, vec}, {21'd0, exp});
      chk({name, "_busy_cycles"}, bcnt, len);
      chk({name, "_end_tx"}, {31'd0, TX_OUT}, 32'd1);
      chk({name, "_end_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(posedge CLK); #1;
         chk("reset_idle_tx", {31'd0, TX_OUT}, 32'd1);
         chk("reset_idle_busy", {31'd0, busy}, 32'd0);
      end

      send_frame("even_8F", 8'h8F, 1'b1, 1'b0, 11, 11'b11100011110, 1'b0);
      send_frame("nopar_A8", 8'hA8, 1'b0, 1'b0, 10, 11'b01101010000, 1'b0);
      send_frame("odd_8F", 8'h8F, 1'b1, 1'b1, 11, 11'b10100011110, 1'b0);
      send_frame("stable_8F", 8'h8F, 1'b1, 1'b0, 11, 11'b11100011110, 1'b1);

      // Data_Valid held high: stop bit, one idle cycle, then the next start bit.
      @(negedge CLK);
      P_DATA = 8'hA8; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      repeat (10) @(posedge CLK);
      @(posedge CLK); #1;
      chk("b2b_gap_tx", {31'd0, TX_OUT}, 32'd1);
      chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
      @(posedge CLK); #1;
      Data_Valid = 1'b0;
      chk("b2b_start_tx", {31'd0, TX_OUT}, 32'd0);
      chk("b2b_start_busy", {31'd0, busy}, 32'd1);
      repeat (11) @(posedge CLK);

      // Abort while data bit 3 (a 0 in 0x87) is on the line; Data_Valid during reset is ignored.
      @(negedge CLK);
      P_DATA = 8'h87; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      @(posedge CLK); #1;
      Data_Valid = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("abort_d3_tx", {31'd0, TX_OUT}, 32'd0);
      chk("abort_d3_busy", {31'd0, busy}, 32'd1);
      RST = 1'b1; Data_Valid = 1'b1;
      @(posedge CLK); #1;
      chk("abort_tx", {31'd0, TX_OUT}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0; Data_Valid = 1'b0;
      @(posedge CLK); #1;
      chk("post_abort_idle_tx", {31'd0, TX_OUT}, 32'd1);
      chk("post_abort_idle_busy", {31'd0, busy}, 32'd0);
      send_frame("post_abort_A8", 8'hA8, 1'b0, 1'b0, 10, 11'b01101010000, 1'b0);

      repeat (3) @(posedge CLK);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
